// File: rtl/sampctl_pkg.sv
// sampctl_pkg: shared types and default parameter constants for the
// sampling-switch sequencer (sampctl_seq) and its timer sub-module.
//   state_t   : sequencer FSM state encoding
//   N_CH_DEF  : default number of comparator channels
//   CNT_W_DEF : default width of timing fields and the down-counter
package sampctl_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SAMP,
    STAG,
    DONE
  } state_t;

endpackage

// File: rtl/sampctl_timer.sv
// sampctl_timer: loadable down-counter with a zero flag. A load value of
// N-1 makes the zero flag rise N-1 cycles later, so the owning FSM state
// lasts exactly N cycles. The counter stops at zero and never wraps.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset (clears the count)
//   load     : load load_val this cycle (has priority over counting)
//   load_val : reload value
//   zero     : count is zero
module sampctl_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sampctl_seq.sv
// sampctl_seq: timed multi-channel sampling-switch sequencer for the SAR
// front-end. A rising edge on seq_samp (accepted only in IDLE) launches one
// window: lead dead-time, n+p sample phase, then p-only stagger, then a
// one-cycle done pulse. Enables and timing fields are latched at trigger.
// Optional feature (macro SAMPCTL_SEQ_OVR_EN): ovr_cnt output counting
// triggers ignored because a window was in progress, saturating at 255.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   seq_samp                   : edge-sensitive sampling trigger
//   samp_p_en, samp_n_en       : per-channel enables, latched at trigger
//   cfg_dead                   : lead cycles before switch turn-on
//   cfg_samp_len               : n-side on-time (0 behaves as 1)
//   cfg_stagger                : extra cycles p stays on after n
//   switch_p, switch_n         : registered switch controls
//   samp_busy, samp_done       : window in progress / end-of-window pulse
//   ovr_cnt (optional)         : ignored-trigger counter
module sampctl_seq
  import sampctl_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seq_samp,
  input  logic [N_CH-1:0]  samp_p_en,
  input  logic [N_CH-1:0]  samp_n_en,
  input  logic [CNT_W-1:0] cfg_dead,
  input  logic [CNT_W-1:0] cfg_samp_len,
  input  logic [CNT_W-1:0] cfg_stagger,
  output logic [N_CH-1:0]  switch_p,
  output logic [N_CH-1:0]  switch_n,
  output logic             samp_busy,
  output logic             samp_done
`ifdef SAMPCTL_SEQ_OVR_EN
  ,
  output logic [7:0]       ovr_cnt
`endif
);

  state_t           state, state_nxt;
  logic             seq_hist;
  logic             trig;
  logic [N_CH-1:0]  p_lat, n_lat;
  logic [CNT_W-1:0] len_lat, stag_lat;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  // Timer reload for a phase of 'cycles' cycles; 0 collapses to a
  // single cycle, which is what cfg_samp_len=0 needs.
  function automatic logic [CNT_W-1:0] reload_of(input logic [CNT_W-1:0] cycles);
    return (cycles == '0) ? '0 : cycles - CNT_W'(1);
  endfunction

  assign trig = seq_samp & ~seq_hist;

  sampctl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next state and timer reload. The entry from IDLE uses the live config
  // inputs since the latches only take them on this same edge.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      IDLE: begin
        if (trig) begin
          tmr_load = 1'b1;
          if (cfg_dead != '0) begin
            state_nxt = LEAD;
            tmr_val   = reload_of(cfg_dead);
          end else begin
            state_nxt = SAMP;
            tmr_val   = reload_of(cfg_samp_len);
          end
        end
      end
      LEAD: begin
        if (tmr_zero) begin
          state_nxt = SAMP;
          tmr_load  = 1'b1;
          tmr_val   = reload_of(len_lat);
        end
      end
      SAMP: begin
        if (tmr_zero) begin
          if (stag_lat != '0) begin
            state_nxt = STAG;
            tmr_load  = 1'b1;
            tmr_val   = reload_of(stag_lat);
          end else begin
            state_nxt = DONE;
          end
        end
      end
      STAG: begin
        if (tmr_zero) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so switches trail the
  // state register by one edge and come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      seq_hist  <= 1'b0;
      p_lat     <= '0;
      n_lat     <= '0;
      len_lat   <= '0;
      stag_lat  <= '0;
      switch_p  <= '0;
      switch_n  <= '0;
      samp_busy <= 1'b0;
      samp_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      seq_hist <= seq_samp;
      if (state == IDLE && trig) begin
        p_lat    <= samp_p_en;
        n_lat    <= samp_n_en;
        len_lat  <= cfg_samp_len;
        stag_lat <= cfg_stagger;
      end
      switch_p  <= (state == SAMP || state == STAG) ? p_lat : '0;
      // n is gated by p so an n-only channel can never close its n switch
      // without the matching p switch.
      switch_n  <= (state == SAMP) ? (n_lat & p_lat) : '0;
      samp_busy <= (state_nxt != IDLE);
      samp_done <= (state == DONE);
    end
  end

`ifdef SAMPCTL_SEQ_OVR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovr_cnt <= '0;
    end else if (trig && state != IDLE && ovr_cnt != 8'hFF) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sampctl_seq.sv
// tb_sampctl_seq: directed self-checking bench for sampctl_seq. Each window
// pushes its expected per-cycle outputs (derived from D, L, S and the
// enables) into a scoreboard queue; every cycle the head is popped and
// compared with the DUT outputs. Build with +define+SAMPCTL_SEQ_OVR_EN to
// also check the ignored-trigger counter.
module tb_sampctl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seq_samp;
  logic [3:0] samp_p_en, samp_n_en;
  logic [7:0] cfg_dead, cfg_samp_len, cfg_stagger;
  logic [3:0] switch_p, switch_n;
  logic       samp_busy, samp_done;
`ifdef SAMPCTL_SEQ_OVR_EN
  logic [7:0] ovr_cnt;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  typedef struct {
    int         t;
    logic [3:0] p;
    logic [3:0] n;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sampctl_seq #(.N_CH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seq_samp     (seq_samp),
    .samp_p_en    (samp_p_en),
    .samp_n_en    (samp_n_en),
    .cfg_dead     (cfg_dead),
    .cfg_samp_len (cfg_samp_len),
    .cfg_stagger  (cfg_stagger),
    .switch_p     (switch_p),
    .switch_n     (switch_n),
    .samp_busy    (samp_busy),
    .samp_done    (samp_done)
`ifdef SAMPCTL_SEQ_OVR_EN
    ,
    .ovr_cnt      (ovr_cnt)
`endif
  );

  task automatic check(input string tag, input int t, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, got, exp);
    end
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check("switch_p",  e.t, {4'b0, switch_p},  {4'b0, e.p});
      check("switch_n",  e.t, {4'b0, switch_n},  {4'b0, e.n});
      check("samp_busy", e.t, {7'b0, samp_busy}, {7'b0, e.busy});
      check("samp_done", e.t, {7'b0, samp_done}, {7'b0, e.done});
    end
  endtask

  // mode: 0 single pulse, 1 retrigger in SAMP and in DONE, 2 hold high,
  //       3 toggle every other edge, 4 change enables/config mid-window
  task automatic window(input logic [3:0] p, input logic [3:0] n, input int d,
                        input int l, input int s, input int mode, input int idle_after);
    int   lp;
    int   tend;
    exp_t e;
    lp   = (l == 0) ? 1 : l;
    tend = 1 + d + lp + s;
    for (int t = 0; t <= tend + idle_after; t++) begin
      e.t    = t;
      e.p    = (t >= 1 + d && t < tend) ? p : 4'b0;
      e.n    = (t >= 1 + d && t < 1 + d + lp) ? (n & p) : 4'b0;
      e.busy = (t < tend);
      e.done = (t == tend);
      sb.push_back(e);
    end
    @(negedge clk);
    samp_p_en    = p;
    samp_n_en    = n;
    cfg_dead     = 8'(d);
    cfg_samp_len = 8'(l);
    cfg_stagger  = 8'(s);
    seq_samp     = 1'b1;
    for (int t = 0; t <= tend + idle_after; t++) begin
      @(posedge clk);
      @(negedge clk);
      check_pop();
      case (mode)
        1:       seq_samp = (t == d + 1) || (t == tend - 1);
        2:       seq_samp = 1'b1;
        3:       seq_samp = (t % 2 == 1) && (t < tend - 1);
        4: begin
          seq_samp = 1'b0;
          if (t == d + 2) begin
            samp_p_en    = ~p;
            samp_n_en    = ~n;
            cfg_samp_len = 8'd1;
            cfg_dead     = 8'd7;
            cfg_stagger  = 8'd0;
          end
        end
        default: seq_samp = 1'b0;
      endcase
    end
    seq_samp = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    seq_samp     = 1'b0;
    samp_p_en    = '0;
    samp_n_en    = '0;
    cfg_dead     = '0;
    cfg_samp_len = '0;
    cfg_stagger  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_switch_p", 0, {4'b0, switch_p}, 8'h00);
    check("rst_switch_n", 0, {4'b0, switch_n}, 8'h00);
    check("rst_busy",     0, {7'b0, samp_busy}, 8'h00);
    check("rst_done",     0, {7'b0, samp_done}, 8'h00);
`ifdef SAMPCTL_SEQ_OVR_EN
    check("rst_ovr_cnt",  0, ovr_cnt, 8'h00);
`endif
    rst_n = 1'b1;

    // Reset in the middle of SAMP
    @(negedge clk);
    samp_p_en    = 4'b1111;
    samp_n_en    = 4'b1111;
    cfg_dead     = 8'd1;
    cfg_samp_len = 8'd10;
    cfg_stagger  = 8'd2;
    seq_samp     = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      seq_samp = 1'b0;
    end
    check("pre_rst_switch_p", 3, {4'b0, switch_p}, 8'h0F);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_switch_p", 0, {4'b0, switch_p}, 8'h00);
    check("midrst_switch_n", 0, {4'b0, switch_n}, 8'h00);
    check("midrst_busy",     0, {7'b0, samp_busy}, 8'h00);
    check("midrst_done",     0, {7'b0, samp_done}, 8'h00);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("postrst_busy",     i, {7'b0, samp_busy}, 8'h00);
      check("postrst_done",     i, {7'b0, samp_done}, 8'h00);
      check("postrst_switch_p", i, {4'b0, switch_p}, 8'h00);
    end

    // Basic window, channel 2 disabled
    window(4'b1011, 4'b1011, 2, 5, 3, 0, 2);
    // All timing fields zero
    window(4'b1111, 4'b1111, 0, 0, 0, 0, 2);
    // n-only channel 0 must stay low, p-only channel 3 runs p alone
    window(4'b1110, 4'b0111, 1, 3, 2, 0, 1);
    // Enables and config change during SAMP
    window(4'b0110, 4'b0110, 1, 4, 2, 4, 2);
    // Retrigger during SAMP and during DONE
    window(4'b1011, 4'b1011, 2, 5, 3, 1, 3);
`ifdef SAMPCTL_SEQ_OVR_EN
    check("ovr_cnt_after_retrig", 0, ovr_cnt, 8'd2);
`endif
    // Level hold for 1000 cycles with maximum sample length
    window(4'b1111, 4'b1111, 1, 255, 0, 2, 742);
    // Long window with 260 ignored edges
    window(4'b0001, 4'b0001, 255, 255, 10, 3, 2);
`ifdef SAMPCTL_SEQ_OVR_EN
    check("ovr_cnt_saturated", 0, ovr_cnt, 8'd255);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
